fat16_rr_sched: RTL

Scheduler in front of the 16-input fat-tree encoder. It captures single-cycle hit pulses from 16 requesters into a sticky pending register and serves them one at a time. For each served requester it presents the 4-bit index with a valid/ready handshake, then clears that requester's pending bit. Arbitration is round-robin, or fixed priority when the round-robin feature is compiled out. Requesters are never lost unless a second hit arrives while they are already pending; that case is flagged.

---
 rtl/fat16_rr_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fat16_rr_sched.sv
// Purpose: 16-requester scheduler in front of the fat-tree encoder; sticky pending capture, one-at-a-time service.
// Latency: 2 cycles from the capture edge to idx_valid; one index at most every 2 cycles.
// Backpressure: idx_out is held with idx_valid until idx_ready; pending hits keep accumulating meanwhile.
//
// Build option: define FAT16_SCHED_RR_EN for round-robin selection with a rotating pointer;
// leave it undefined for fixed priority (highest pending index wins, no pointer register).
module fat16_rr_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_in,
    input  logic        en,
    input  logic        idx_ready,
    input  logic        clr_ovf,
    output logic [3:0]  idx_out,
    output logic        idx_valid,
    output logic [15:0] pend_out,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2
    } state_t;

    state_t      state;
    logic        hs;
    logic [15:0] clr_mask;
    logic [15:0] pend_next;
    logic        ovf_hit;
    logic [3:0]  winner;

`ifdef FAT16_SCHED_RR_EN
    logic [3:0]  ptr;
    logic [3:0]  cand;
    logic        found;
`endif

    // Handshake, the bit it retires, and the next pending value (a same-cycle hit beats the clear).
    always_comb begin
        hs        = idx_valid & idx_ready;
        clr_mask  = hs ? (16'h0001 << idx_out) : 16'h0000;
        pend_next = (pend_out & ~clr_mask) | req_in;
        ovf_hit   = |(req_in & pend_out & ~clr_mask);
    end

`ifdef FAT16_SCHED_RR_EN
    // Round-robin pick: first pending bit at or above ptr, wrapping 15 -> 0.
    always_comb begin
        winner = ptr;
        cand   = 4'd0;
        found  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr + 4'(i);
            if (!found && pend_out[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`else
    // Fixed-priority pick: the ascending scan leaves the highest pending index as winner.
    always_comb begin
        winner = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pend_out[i]) begin
                winner = 4'(i);
            end
        end
    end
`endif

    // Pending register and sticky overflow; a new hit takes priority over clr_ovf.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_out <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            pend_out <= pend_next;
            if (ovf_hit) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Service FSM with registered idx_out/idx_valid/busy; en only gates starting a new selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx_out   <= 4'd0;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef FAT16_SCHED_RR_EN
            ptr       <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (en && (pend_out != 16'h0000)) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    // pend_out cannot be empty here: bits only leave via a handshake.
                    idx_out   <= winner;
                    idx_valid <= 1'b1;
                    state     <= OFFER;
                end
                OFFER: begin
                    if (hs) begin
                        idx_valid <= 1'b0;
`ifdef FAT16_SCHED_RR_EN
                        ptr       <= idx_out + 4'd1;
`endif
                        if (en && (pend_next != 16'h0000)) begin
                            state <= SCAN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
